// File: rtl/rhythm_pkg.sv
// rhythm_pkg: game states, keycodes, score limit and lane popcount shared by the rhythm blocks
package rhythm_pkg;
  typedef enum logic [1:0] {Idle, Playing, Done} state_t;
  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_RESET = 8'h01;
  localparam int SCORE_MAX = 9999;
  localparam int POP_W = 64;
  function automatic logic [6:0] popcount(input logic [POP_W-1:0] v);
    popcount = '0;
    for (int i = 0; i < POP_W; i++) popcount = popcount + 7'(v[i]);
  endfunction
endpackage

// File: rtl/bin_to_bcd4.sv
// bin_to_bcd4: combinational double-dabble conversion of a 14-bit value to four BCD digits
module bin_to_bcd4 (
  input  logic [13:0] i_bin,
  output logic [15:0] o_bcd
);
  logic [29:0] w_sr;
  always_comb begin
    w_sr = {16'd0, i_bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++)
        w_sr[14+4*d +: 4] = (w_sr[14+4*d +: 4] >= 4'd5) ? w_sr[14+4*d +: 4] + 4'd3 : w_sr[14+4*d +: 4];
      w_sr = w_sr << 1;
    end
    o_bcd = w_sr[29:14];
  end
endmodule

// File: rtl/score_keeper.sv
// score_keeper: per-frame hit edge detect, score/combo/statistics and Idle/Playing/Done game sequence
// SCORE_COMBO_BONUS_EN doubles points while the combo is at or above COMBO_THRESH
module score_keeper
  import rhythm_pkg::*;
#(
  parameter int N_DROPS      = 32,
  parameter int POINTS       = 10,
  parameter int COMBO_THRESH = 10,
  parameter int COMBO_WINDOW = 240,
  parameter int SONG_FRAMES  = 3600,
  parameter int SCORE_MAX    = rhythm_pkg::SCORE_MAX
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [N_DROPS-1:0] hits,
  output logic [15:0]        score_bcd,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo,
  output logic [9:0]         hit_count,
  output logic               playing,
  output logic               game_over
);
  localparam int FW = $clog2(SONG_FRAMES + 1);
  localparam int GW = $clog2(COMBO_WINDOW + 1);
  state_t             r_state, w_next;
  logic [N_DROPS-1:0] r_prev, w_rise;
  logic [13:0]        r_score, w_score_nx;
  logic [7:0]         r_combo, r_max, w_combo_nx, w_max_nx;
  logic [9:0]         r_hits, w_hits_nx;
  logic [FW-1:0]      r_frame;
  logic [GW-1:0]      r_gap;
  logic [6:0]         w_n;
  logic [1:0]         w_mult;
  logic [17:0]        w_sum;
  logic [8:0]         w_combo_sum;
  logic [10:0]        w_hits_sum;
  logic               w_hit, w_expire, w_last, w_start;
  assign w_rise = hits & ~r_prev;
  assign w_n    = popcount(POP_W'(w_rise));
  assign w_hit  = |w_rise;
`ifdef SCORE_COMBO_BONUS_EN
  assign w_mult = (r_combo >= 8'(COMBO_THRESH)) ? 2'd2 : 2'd1;
`else
  assign w_mult = 2'd1;
`endif
  always_comb begin
    w_sum       = 18'(r_score) + 18'(w_n) * 18'(POINTS) * 18'(w_mult);
    w_score_nx  = (w_sum > 18'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_sum[13:0];
    w_combo_sum = {1'b0, r_combo} + 9'(w_n);
    w_combo_nx  = w_combo_sum[8] ? 8'hff : w_combo_sum[7:0];
    w_max_nx    = (w_combo_nx > r_max) ? w_combo_nx : r_max;
    w_hits_sum  = {1'b0, r_hits} + 11'(w_n);
    w_hits_nx   = w_hits_sum[10] ? 10'h3ff : w_hits_sum[9:0];
    w_expire    = r_gap == GW'(COMBO_WINDOW - 1);
    w_last      = r_frame == FW'(SONG_FRAMES - 1);
    w_start     = (r_state == Idle) && (keycode == KEY_START);
  end
  always_ff @(posedge frame_clk)
    r_state <= Reset ? Idle : w_next;
  always_comb begin
    w_next = (r_state == Idle)    ? (w_start ? Playing : Idle) :
             (r_state == Playing) ? (w_last ? Done : Playing) :
             (keycode == KEY_RESET) ? Idle : Done;
  end
  always_comb begin
    playing   = r_state == Playing;
    game_over = r_state == Done;
  end
  // Lanes are sampled in every state so hits held across a start never register as edges
  always_ff @(posedge frame_clk) begin
    r_prev <= hits;
    if (Reset || w_start) begin
      r_score <= '0;
      r_combo <= '0;
      r_max   <= '0;
      r_hits  <= '0;
      r_frame <= '0;
      r_gap   <= '0;
    end else if (r_state == Playing) begin
      r_score <= w_score_nx;
      r_hits  <= w_hits_nx;
      r_max   <= w_max_nx;
      r_frame <= r_frame + FW'(1);
      r_combo <= w_hit ? w_combo_nx : w_expire ? '0 : r_combo;
      r_gap   <= (w_hit || w_expire) ? '0 : r_gap + GW'(1);
    end
  end
  bin_to_bcd4 u_bcd (.i_bin(r_score), .o_bcd(score_bcd));
  assign combo     = r_combo;
  assign max_combo = r_max;
  assign hit_count = r_hits;
endmodule

// File: doc/score_keeper.md
# score_keeper

Per-frame score and combo accumulator at the receiving end of the dropper `scoreNN` outputs. Samples the concatenated hit flags of all droppers once per `frame_clk` and rising-edge detects each lane, because a dropper holds its flag high until it is reset. Converts new hits into points, combo and statistics, and runs the game-level Idle/Playing/Done sequence using the same keycodes as the droppers. Its outputs feed the HUD text renderer.

## Interface
- `N_DROPS`, 32: number of dropper hit lanes.
- `POINTS`, 10: base points per hit.
- `COMBO_THRESH`, 10: combo value at or above which a hit scores double.
- `COMBO_WINDOW`, 240: frames without a hit before the combo clears.
- `SONG_FRAMES`, 3600: frames in Playing before Done.
- `SCORE_MAX`, 9999: score saturation value.
- `frame_clk`  in  1  frame clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `keycode`  in  8  primary keycode. `8'h2c` starts a game; `8'h01` returns to Idle.
- `hits`  in  N_DROPS  concatenated dropper `scoreNN` flags; bit i is dropper i.
- `score_bcd`  out  16  four-digit BCD score.
- `combo`  out  8  current combo, saturating at 255.
- `max_combo`  out  8  highest combo reached this game.
- `hit_count`  out  10  total hits, saturating at 1023.
- `playing`  out  1  high in Playing.
- `game_over`  out  1  high in Done.

## Operation
- States:
  - Idle: `keycode==8'h2c` → Playing.
  - Playing: `frame_cnt==SONG_FRAMES-1` → Done. `8'h2c` is ignored here.
  - Done: `keycode==8'h01` → Idle.
- Edge detect: `rise = hits & ~prev_hits`. `prev_hits <= hits` every cycle in every state.
  - Lanes already high when a game starts are never counted.
- Idle→Playing transition clears `score`, `combo`, `max_combo`, `hit_count`, `frame_cnt` and `gap_cnt`.
- Playing, with `n = popcount(rise)`, per frame:
  - `score += n*POINTS*(combo>=COMBO_THRESH ? 2 : 1)`, clamped to SCORE_MAX. The multiplier uses the combo value from before this frame's update.
  - `combo += n`, saturating at 255. `hit_count += n`, saturating at 1023.
  - `max_combo = max(max_combo, new combo)`.
  - `n>0`: `gap_cnt <= 0`.
  - `n==0`: `gap_cnt` increments. When it reaches COMBO_WINDOW-1, `combo <= 0` and `gap_cnt <= 0`.
  - `frame_cnt` increments every frame.
- Done: all statistics are frozen and hits are ignored. Values persist through Idle until the next start.
- Arithmetic:
  - Internal binary score is 14 bits.
  - Per-frame add is computed at full width (at least 16 bits) before clamping.
  - `score_bcd` is the combinational double-dabble conversion of the registered binary score.

## Timing
- Reset: state Idle.
  - All counters and `score_bcd` are 0.
  - `prev_hits` takes the value of `hits` (no spurious edges after reset).
  - `playing=0`, `game_over=0`.
- Latency: a lane rising before edge k is reflected on all outputs after edge k (one frame).
- Simultaneous events:
  - A hit in the same frame as combo-window expiry counts as a hit: combo increments and `gap_cnt` clears.
  - A hit in the last Playing frame is counted, and the state is Done after that same edge.
  - Several lanes rising together score n hits at the same multiplier.
- Reset mid-game: returns to Idle next edge with everything cleared. `Reset` overrides `keycode`.

## Configuration
- `SCORE_COMBO_BONUS_EN`:
  - Defined: double-points rule above.
  - Undefined: multiplier fixed at 1. `combo`, `max_combo` and the combo window still operate.

## Structure
- Shared package `rhythm_pkg`:
  - State enum `{Idle, Playing, Done}`.
  - Keycode constants `KEY_START=8'h2c`, `KEY_RESET=8'h01`.
  - `SCORE_MAX`.
- Sub-module `bin_to_bcd4`: 14-bit binary to 16-bit BCD, combinational double dabble, reused by the HUD timer.
- Popcount is a function in `rhythm_pkg`.

## Test plan
- Reset, then `keycode=8'h2c`; pulse `hits[3]` high and hold → after one frame `score_bcd=16'h0010`, `combo=1`, `hit_count=1`. Holding adds nothing.
- Start; raise 10 separate lanes on 10 frames, then an 11th → `score_bcd=16'h0120` (100+20), `combo=11`.
  - Without `SCORE_COMBO_BONUS_EN` → `16'h0110`.
- Start; one hit, then 240 idle frames → `combo=0`, `max_combo=1`.
  - Hit landing exactly on frame 240 → `combo=2`.
- Start; raise `hits[7:0]` in one frame → `combo=8`, `hit_count=8`, `score_bcd=16'h0080`.
- `hits[0]` already high at start → no score. Force score near 9995 and hit → `score_bcd=16'h9999`.
- `SONG_FRAMES=8`: after 8 Playing frames `game_over=1` and later hits are ignored.
  - `8'h01` → Idle, `playing=0`, score held.
  - `8'h2c` → score 0.
